// File: rtl/alu_arbiter_if.sv
// Request, ALU and response bundle shared by alu_arbiter and its environment.
// Operand width defaults to the WORD_WIDTH macro (32 when the macro is not defined).
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

interface alu_arbiter_if #(
    parameter int WORD_WIDTH = `WORD_WIDTH
);
    logic [1:0]            req_valid;
    logic [1:0]            req_ready;
    logic [3:0]            req0_cmd;
    logic [WORD_WIDTH-1:0] req0_val1;
    logic [WORD_WIDTH-1:0] req0_val2;
    logic                  req0_set_flags;
    logic [3:0]            req1_cmd;
    logic [WORD_WIDTH-1:0] req1_val1;
    logic [WORD_WIDTH-1:0] req1_val2;
    logic                  req1_set_flags;
    logic [3:0]            alu_cmd;
    logic [WORD_WIDTH-1:0] alu_val1;
    logic [WORD_WIDTH-1:0] alu_val2;
    logic                  alu_carry;
    logic [WORD_WIDTH-1:0] alu_res;
    logic [3:0]            alu_sr;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic                  rsp_id;
    logic [WORD_WIDTH-1:0] rsp_res;
    logic [3:0]            rsp_sr;
    logic [3:0]            flags;

    modport slave (
        input  req_valid, req0_cmd, req0_val1, req0_val2, req0_set_flags,
               req1_cmd, req1_val1, req1_val2, req1_set_flags,
               alu_res, alu_sr, rsp_ready,
        output req_ready, alu_cmd, alu_val1, alu_val2, alu_carry,
               rsp_valid, rsp_id, rsp_res, rsp_sr, flags
    );

    modport master (
        output req_valid, req0_cmd, req0_val1, req0_val2, req0_set_flags,
               req1_cmd, req1_val1, req1_val2, req1_set_flags,
               alu_res, alu_sr, rsp_ready,
        input  req_ready, alu_cmd, alu_val1, alu_val2, alu_carry,
               rsp_valid, rsp_id, rsp_res, rsp_sr, flags
    );
endinterface

// File: rtl/alu_arbiter.sv
// Two-requester arbiter for the shared EX-stage ALU: registered response channel plus status register.
// Define ALU_ARB_FIXED_PRIO_EN for fixed req0 priority; the default build is round-robin.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module alu_arbiter #(
    parameter int         WORD_WIDTH = `WORD_WIDTH,
    parameter logic [3:0] SR_RESET   = 4'b0000
) (
    input logic          clk,
    input logic          rst,
    alu_arbiter_if.slave bus
);
    typedef enum logic {IDLE, RESP} state_e;

    state_e                state_q, state_d;
    logic                  rsp_id_q, rsp_id_d;
    logic [WORD_WIDTH-1:0] rsp_res_q, rsp_res_d;
    logic [3:0]            rsp_sr_q, rsp_sr_d;
    logic [3:0]            flags_q, flags_d;
    logic                  can_issue, issue, grant, contend_pick, grant_set_flags;

    always_comb begin
        can_issue       = (state_q == IDLE) || bus.rsp_ready;
        issue           = can_issue && (bus.req_valid != 2'b00);
        grant           = (bus.req_valid == 2'b11) ? contend_pick : bus.req_valid[1];
        grant_set_flags = grant ? bus.req1_set_flags : bus.req0_set_flags;
    end

    // NOTE: every output of a combinational block gets a default first, so no latch is inferred.
    always_comb begin
        bus.req_ready = 2'b00;
        bus.alu_cmd   = 4'h0;
        bus.alu_val1  = '0;
        bus.alu_val2  = '0;
        if (issue) begin
            bus.req_ready = grant ? 2'b10 : 2'b01;
            bus.alu_cmd   = grant ? bus.req1_cmd  : bus.req0_cmd;
            bus.alu_val1  = grant ? bus.req1_val1 : bus.req0_val1;
            bus.alu_val2  = grant ? bus.req1_val2 : bus.req0_val2;
        end
    end

    always_comb begin
        state_d   = state_q;
        rsp_id_d  = rsp_id_q;
        rsp_res_d = rsp_res_q;
        rsp_sr_d  = rsp_sr_q;
        flags_d   = flags_q;
        if (issue) begin
            state_d   = RESP;
            rsp_id_d  = grant;
            rsp_res_d = bus.alu_res;
            rsp_sr_d  = bus.alu_sr;
            if (grant_set_flags) flags_d = bus.alu_sr;
        end else if ((state_q == RESP) && bus.rsp_ready) begin
            state_d = IDLE;
        end
    end

    // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            rsp_id_q  <= 1'b0;
            rsp_res_q <= '0;
            rsp_sr_q  <= 4'b0000;
            flags_q   <= SR_RESET;
        end else begin
            state_q   <= state_d;
            rsp_id_q  <= rsp_id_d;
            rsp_res_q <= rsp_res_d;
            rsp_sr_q  <= rsp_sr_d;
            flags_q   <= flags_d;
        end
    end

`ifdef ALU_ARB_FIXED_PRIO_EN
    assign contend_pick = 1'b0;
`else
    logic last_grant_q, last_grant_d;

    assign last_grant_d = issue ? grant : last_grant_q;
    assign contend_pick = ~last_grant_q;

    // Resetting to 1 makes the first contended grant go to req0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) last_grant_q <= 1'b1;
        else     last_grant_q <= last_grant_d;
    end
`endif

    assign bus.alu_carry = flags_q[2];
    assign bus.rsp_valid = (state_q == RESP);
    assign bus.rsp_id    = rsp_id_q;
    assign bus.rsp_res   = rsp_res_q;
    assign bus.rsp_sr    = rsp_sr_q;
    assign bus.flags     = flags_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: behavioural ALU, response scoreboard, one task per scenario.
module tb_alu_arbiter;
    localparam int         WW     = 32;
    localparam logic [3:0] EX_ADD = 4'h1;
    localparam logic [3:0] EX_ADC = 4'h2;
    localparam logic [3:0] EX_SUB = 4'h3;

    typedef struct packed {
        logic          id;
        logic [WW-1:0] res;
        logic [3:0]    sr;
    } rsp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.WORD_WIDTH(WW)) bus();

    alu_arbiter #(.WORD_WIDTH(WW), .SR_RESET(4'b0000)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    rsp_t       sb[$];
    rsp_t       mon_exp;
    int         n_checks = 0;
    int         n_fail   = 0;
    logic [3:0] exp_flags;
    logic       exp_last;

    // Result and SR {Z,C,N,V}; for SUB, C is the borrow.
    function automatic logic [WW+3:0] alu_fn(input logic [3:0] cmd, input logic [WW-1:0] a,
                                             input logic [WW-1:0] b, input logic cin);
        logic [WW:0] s;
        logic        v;
        s = '0;
        v = 1'b0;
        case (cmd)
            EX_ADD: begin
                s = {1'b0, a} + {1'b0, b};
                v = (a[WW-1] == b[WW-1]) && (s[WW-1] != a[WW-1]);
            end
            EX_ADC: begin
                s = {1'b0, a} + {1'b0, b} + {{WW{1'b0}}, cin};
                v = (a[WW-1] == b[WW-1]) && (s[WW-1] != a[WW-1]);
            end
            EX_SUB: begin
                s = {1'b0, a} - {1'b0, b};
                v = (a[WW-1] != b[WW-1]) && (s[WW-1] != a[WW-1]);
            end
            default: s = '0;
        endcase
        return {s[WW-1:0], (s[WW-1:0] == '0), s[WW], s[WW-1], v};
    endfunction

    function automatic logic exp_grant(input logic [1:0] v, input logic last);
        if (v == 2'b11) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
            return 1'b0;
`else
            return ~last;
`endif
        end
        return v[1];
    endfunction

    always_comb begin
        {bus.alu_res, bus.alu_sr} = alu_fn(bus.alu_cmd, bus.alu_val1, bus.alu_val2, bus.alu_carry);
    end

    // Scoreboard: compare every response as the consumer takes it.
    always @(negedge clk) begin
        if (!rst && bus.rsp_valid && bus.rsp_ready) begin
            n_checks++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL sb_unexpected: got id=%0d res=%h sr=%b, required no response",
                         bus.rsp_id, bus.rsp_res, bus.rsp_sr);
            end else begin
                mon_exp = sb.pop_front();
                if ({bus.rsp_id, bus.rsp_res, bus.rsp_sr} !== mon_exp) begin
                    n_fail++;
                    $display("FAIL sb_rsp: got id=%0d res=%h sr=%b, required id=%0d res=%h sr=%b",
                             bus.rsp_id, bus.rsp_res, bus.rsp_sr, mon_exp.id, mon_exp.res, mon_exp.sr);
                end
            end
        end
    end

    task automatic set_req(input int i, input logic [3:0] cmd, input logic [WW-1:0] a,
                           input logic [WW-1:0] b, input logic sf);
        if (i == 0) begin
            bus.req0_cmd = cmd; bus.req0_val1 = a; bus.req0_val2 = b; bus.req0_set_flags = sf;
        end else begin
            bus.req1_cmd = cmd; bus.req1_val1 = a; bus.req1_val2 = b; bus.req1_set_flags = sf;
        end
    endtask

    // Called at a negedge of an expected issue cycle; returns at posedge+1 after the issue edge.
    task automatic drive_issue_cycle(input logic [1:0] v, output logic g);
        logic [WW+3:0] r;
        logic          sf;
        rsp_t          e;
        g = exp_grant(v, exp_last);
        n_checks++;
        if (bus.req_ready !== (g ? 2'b10 : 2'b01)) begin
            n_fail++;
            $display("FAIL grant: req_ready=%b, required %b", bus.req_ready, g ? 2'b10 : 2'b01);
        end
        n_checks++;
        if (bus.alu_carry !== exp_flags[2]) begin
            n_fail++;
            $display("FAIL carry_in: alu_carry=%b, required %b", bus.alu_carry, exp_flags[2]);
        end
        if (g) begin
            r  = alu_fn(bus.req1_cmd, bus.req1_val1, bus.req1_val2, exp_flags[2]);
            sf = bus.req1_set_flags;
        end else begin
            r  = alu_fn(bus.req0_cmd, bus.req0_val1, bus.req0_val2, exp_flags[2]);
            sf = bus.req0_set_flags;
        end
        e = rsp_t'({g, r});
        sb.push_back(e);
        if (sf) exp_flags = e.sr;
        exp_last = g;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        exp_flags = 4'b0000;
        exp_last  = 1'b1;
    endtask

    task automatic test_reset();
        apply_reset();
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_sr} !== {1'b0, 1'b0, {WW{1'b0}}, 4'b0000}) begin
            n_fail++;
            $display("FAIL reset_rsp: valid=%b id=%b res=%h sr=%b, required all zero",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_sr);
        end
        n_checks++;
        if (bus.flags !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: flags=%b, required 0000", bus.flags);
        end
        n_checks++;
        if ({bus.req_ready, bus.alu_cmd} !== 6'b0) begin
            n_fail++;
            $display("FAIL reset_idle: req_ready=%b alu_cmd=%h, required 00/0", bus.req_ready, bus.alu_cmd);
        end
    endtask

    task automatic test_single_ops();
        logic g;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        // ADD 5+3 without flag update
        set_req(0, EX_ADD, 32'd5, 32'd3, 1'b0);
        bus.req_valid = 2'b01;
        @(negedge clk);
        drive_issue_cycle(2'b01, g);
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.flags} !== {1'b1, 1'b0, 32'd8, 4'b0000}) begin
            n_fail++;
            $display("FAIL t1_add: valid=%b id=%b res=%h flags=%b, required 1/0/8/0000",
                     bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.flags);
        end
        @(posedge clk);
        #1;
        // Carry-producing ADD with flag update, then ADC consumes the carry
        set_req(0, EX_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        bus.req_valid = 2'b01;
        @(negedge clk);
        drive_issue_cycle(2'b01, g);
        set_req(0, EX_ADC, 32'd1, 32'd1, 1'b0);
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_res, bus.rsp_sr, bus.flags, bus.alu_carry} !== {32'd0, 4'b1100, 4'b1100, 1'b1}) begin
            n_fail++;
            $display("FAIL t2_carry: res=%h sr=%b flags=%b carry=%b, required 0/1100/1100/1",
                     bus.rsp_res, bus.rsp_sr, bus.flags, bus.alu_carry);
        end
        drive_issue_cycle(2'b01, g);
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if (bus.rsp_res !== 32'd3) begin
            n_fail++;
            $display("FAIL t2_adc: res=%h, required 3", bus.rsp_res);
        end
        @(posedge clk);
        #1;
        // req1 SUB 5-5 with flag update
        set_req(1, EX_SUB, 32'd5, 32'd5, 1'b1);
        bus.req_valid = 2'b10;
        @(negedge clk);
        drive_issue_cycle(2'b10, g);
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_id, bus.rsp_res, bus.flags} !== {1'b1, 32'd0, 4'b1000}) begin
            n_fail++;
            $display("FAIL t3_sub: id=%b res=%h flags=%b, required 1/0/1000",
                     bus.rsp_id, bus.rsp_res, bus.flags);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_round_robin();
        logic g;
        apply_reset();
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        set_req(0, EX_ADD, 32'd10, 32'd20, 1'b0);
        set_req(1, EX_ADC, 32'd100, 32'd200, 1'b0);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            drive_issue_cycle(2'b11, g);
            set_req(int'(g), (k % 2 == 0) ? EX_SUB : EX_ADD, $urandom, $urandom, 1'b0);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back_stall();
        logic g;
        rsp_t held;
        bus.rsp_ready = 1'b1;
        set_req(0, EX_SUB, 32'd7, 32'd9, 1'b0);
        set_req(1, EX_ADD, 32'h7FFF_FFFF, 32'd1, 1'b0);
        bus.req_valid = 2'b11;
        @(negedge clk);
        drive_issue_cycle(2'b11, g);
        bus.rsp_ready = 1'b0;
        held = sb[$];
        set_req(int'(g), EX_ADD, 32'd40, 32'd2, 1'b0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            n_checks++;
            if ({bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_sr} !== {1'b1, held}) begin
                n_fail++;
                $display("FAIL t5_hold: valid=%b id=%b res=%h sr=%b, required 1/%b/%h/%b",
                         bus.rsp_valid, bus.rsp_id, bus.rsp_res, bus.rsp_sr, held.id, held.res, held.sr);
            end
            n_checks++;
            if ({bus.req_ready, bus.alu_cmd} !== 6'b0) begin
                n_fail++;
                $display("FAIL t5_noissue: req_ready=%b alu_cmd=%h, required 00/0", bus.req_ready, bus.alu_cmd);
            end
            @(posedge clk);
            #1;
        end
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        drive_issue_cycle(2'b11, g);
        bus.req_valid = 2'b00;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset_mid_op();
        logic g;
        bus.rsp_ready = 1'b0;
        set_req(0, EX_ADD, 32'hFFFF_FFFF, 32'd1, 1'b1);
        bus.req_valid = 2'b01;
        @(negedge clk);
        drive_issue_cycle(2'b01, g);
        bus.req_valid = 2'b00;
        @(negedge clk);
        n_checks++;
        if ({bus.rsp_valid, bus.flags} !== {1'b1, 4'b1100}) begin
            n_fail++;
            $display("FAIL t6_pre: valid=%b flags=%b, required 1/1100", bus.rsp_valid, bus.flags);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if ({bus.rsp_valid, bus.flags, bus.rsp_res} !== {1'b0, 4'b0000, {WW{1'b0}}}) begin
            n_fail++;
            $display("FAIL t6_async: valid=%b flags=%b res=%h, required 0/0000/0",
                     bus.rsp_valid, bus.flags, bus.rsp_res);
        end
        sb.delete();
        exp_flags = 4'b0000;
        exp_last  = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        set_req(0, EX_ADC, 32'd3, 32'd4, 1'b0);
        set_req(1, EX_SUB, 32'd1, 32'd2, 1'b0);
        bus.req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            drive_issue_cycle(2'b11, g);
            set_req(int'(g), EX_ADD, $urandom, $urandom, 1'b0);
        end
        bus.req_valid = 2'b00;
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        set_req(0, 4'h0, '0, '0, 1'b0);
        set_req(1, 4'h0, '0, '0, 1'b0);
        exp_flags = 4'b0000;
        exp_last  = 1'b1;
        test_reset();
        test_single_ops();
        test_round_robin();
        test_back_to_back_stall();
        test_reset_mid_op();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d responses outstanding, required 0", sb.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
